// File: rtl/histogram_cdf_pkg.sv
// Shared types and RAM-shape constants for the histogram kernel and its CDF sweep.
package histogram_cdf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_NUM_BINS   = 256;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [DEF_DATA_WIDTH-1:0] SAT_MAX = '1;

endpackage

// File: rtl/histogram_cdf_sat_accum.sv
// Saturating running-sum register with a sticky carry-out flag.
module cdf_sat_accum #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  ovf
);

  // MSB of the result is the carry-out; the low bits are already clamped.
  function automatic logic [DATA_WIDTH:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[DATA_WIDTH]) s[DATA_WIDTH-1:0] = '1;
    return s;
  endfunction

  logic [DATA_WIDTH:0] nxt;

  assign nxt = sat_add(sum, din);

  always_ff @(posedge clk) begin
    if (clear) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      sum <= nxt[DATA_WIDTH-1:0];
      ovf <= ovf | nxt[DATA_WIDTH];
    end
  end

endmodule

// File: rtl/histogram_cdf.sv
// Sweeps the finished histogram RAM once, writing the cumulative distribution
// and collecting total / first non-zero CDF / peak bin for equalisation.
module histogram_cdf
  import histogram_cdf_pkg::*;
#(
  parameter int NUM_BINS     = DEF_NUM_BINS,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] hist_raddr,
  input  logic [DATA_WIDTH-1:0] hist_rdata,
  output logic [ADDR_WIDTH-1:0] cdf_waddr,
  output logic [DATA_WIDTH-1:0] cdf_wdata,
  output logic                  cdf_wen,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] total,
  output logic [DATA_WIDTH-1:0] cdf_min,
  output logic [ADDR_WIDTH-1:0] peak_bin,
  output logic [DATA_WIDTH-1:0] peak_count,
  output logic                  overflow
);

  state_t                state, state_nxt;
  logic                  accept;
  logic                  last_addr;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [READ_LATENCY-1:0] vld_p;
  logic [ADDR_WIDTH-1:0] addr_p [READ_LATENCY];
  logic                  arr_vld;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] sum;

  assign last_addr  = (cnt == ADDR_WIDTH'(NUM_BINS - 1));
  assign hist_raddr = (state == ISSUE) ? cnt : '0;
  assign busy       = (state == ISSUE) || (state == DRAIN);
  assign done       = (state == DONE);
  assign arr_vld    = vld_p[READ_LATENCY-1];
  assign arr_addr   = addr_p[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        accept    = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: if (last_addr) state_nxt = DRAIN;
      DRAIN: if (vld_p == '0) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || accept)       cnt <= '0;
    else if (state == ISSUE) cnt <= cnt + 1'b1;
  end

  // ---- read-latency stage: in-flight valid/address follow the RAM pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= (state == ISSUE);
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    addr_p[0] <= cnt;
    for (int i = 1; i < READ_LATENCY; i++) addr_p[i] <= addr_p[i-1];
  end

  // ---- accumulate stage: data for arr_addr is on hist_rdata this cycle
  cdf_sat_accum #(.DATA_WIDTH(DATA_WIDTH)) u_accum (
    .clk   (clk),
    .clear (rst | accept),
    .en    (arr_vld),
    .din   (hist_rdata),
    .sum   (sum),
    .ovf   (overflow)
  );

  assign cdf_wdata = sum;
  assign total     = sum;

  // ---- write stage: registered strobe/address line up with the updated sum
  always_ff @(posedge clk) begin
    if (rst) begin
      cdf_wen    <= 1'b0;
      cdf_waddr  <= '0;
      cdf_min    <= '0;
      peak_bin   <= '0;
      peak_count <= '0;
    end else begin
      cdf_wen <= arr_vld;
      if (arr_vld) cdf_waddr <= arr_addr;
      if (accept) begin
        cdf_min    <= '0;
        peak_bin   <= '0;
        peak_count <= '0;
      end else begin
        if (cdf_wen && cdf_min == '0) cdf_min <= cdf_wdata;
        if (arr_vld && hist_rdata > peak_count) begin
          peak_count <= hist_rdata;
          peak_bin   <= arr_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_histogram_cdf.sv
// Randomized self-checking bench: two instances (read latency 1 and 3) share one histogram.
module tb_histogram_cdf;
  import histogram_cdf_pkg::*;

  localparam int NB = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] hist [NB];

  logic [7:0]  ra_a, wa_a, pb_a, ra_b, wa_b, pb_b;
  logic [31:0] rd_a, wd_a, tot_a, min_a, pc_a;
  logic [31:0] rd_b, wd_b, tot_b, min_b, pc_b;
  logic        we_a, busy_a, done_a, ovf_a, we_b, busy_b, done_b, ovf_b;
  logic [31:0] rdb_p [3];

  always @(posedge clk) rd_a <= hist[ra_a];
  always @(posedge clk) begin
    rdb_p[0] <= hist[ra_b];
    rdb_p[1] <= rdb_p[0];
    rdb_p[2] <= rdb_p[1];
  end
  assign rd_b = rdb_p[2];

  histogram_cdf #(.READ_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .hist_raddr(ra_a), .hist_rdata(rd_a),
    .cdf_waddr(wa_a), .cdf_wdata(wd_a), .cdf_wen(we_a), .busy(busy_a), .done(done_a),
    .total(tot_a), .cdf_min(min_a), .peak_bin(pb_a), .peak_count(pc_a), .overflow(ovf_a));

  histogram_cdf #(.READ_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .hist_raddr(ra_b), .hist_rdata(rd_b),
    .cdf_waddr(wa_b), .cdf_wdata(wd_b), .cdf_wen(we_b), .busy(busy_b), .done(done_b),
    .total(tot_b), .cdf_min(min_b), .peak_bin(pb_b), .peak_count(pc_b), .overflow(ovf_b));

  int n_total = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: cumulative sum clamped at SAT_MAX, stats by direct scan.
  logic [31:0] exp_cdf [NB];
  logic [31:0] exp_total, exp_min, exp_pc;
  logic [7:0]  exp_pb;
  logic        exp_ovf;

  task automatic build_model();
    logic [63:0] s;
    s = 0;
    exp_min = 0; exp_pc = 0; exp_pb = 0; exp_ovf = 0;
    for (int k = 0; k < NB; k++) begin
      s = s + 64'(hist[k]);
      if (s > 64'(SAT_MAX)) begin
        s = 64'(SAT_MAX);
        exp_ovf = 1'b1;
      end
      exp_cdf[k] = s[31:0];
      if (exp_min == 0 && s != 0) exp_min = s[31:0];
      if (hist[k] > exp_pc) begin
        exp_pc = hist[k];
        exp_pb = 8'(k);
      end
    end
    exp_total = exp_cdf[NB-1];
  endtask

  // Per-instance observations, snapshot at the first cycle done is seen.
  int t0 = 0;
  int wr_cnt [2], wr_bad [2], done_at [2], g_wr [2], g_wbad [2];
  logic [31:0] g_total [2], g_min [2], g_pc [2];
  logic [7:0]  g_pb [2], g_ra [2];
  logic        g_ovf [2], g_busy [2], g_rebusy [2];

  task automatic mon(input int d, input logic we, input logic [7:0] wa, input logic [31:0] wd,
                     input logic dn, input logic bs, input logic [31:0] tt, input logic [31:0] mn,
                     input logic [31:0] pc, input logic [7:0] pb, input logic [7:0] ra,
                     input logic ov);
    if (we) begin
      if (int'(wa) != wr_cnt[d] || wd != exp_cdf[wa]) wr_bad[d]++;
      wr_cnt[d]++;
    end
    if (done_at[d] >= 0 && cyc - t0 == done_at[d] + 1) g_rebusy[d] = bs;
    if (dn && done_at[d] < 0 && cyc - t0 >= 2) begin
      done_at[d] = cyc - t0;
      g_wr[d] = wr_cnt[d]; g_wbad[d] = wr_bad[d];
      g_total[d] = tt; g_min[d] = mn; g_pc[d] = pc; g_pb[d] = pb;
      g_ra[d] = ra; g_ovf[d] = ov; g_busy[d] = bs;
    end
  endtask

  always @(negedge clk) begin
    mon(0, we_a, wa_a, wd_a, done_a, busy_a, tot_a, min_a, pc_a, pb_a, ra_a, ovf_a);
    mon(1, we_b, wa_b, wd_b, done_b, busy_b, tot_b, min_b, pc_b, pb_b, ra_b, ovf_b);
  end

  task automatic arm();
    build_model();
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      wr_cnt[d] = 0; wr_bad[d] = 0; done_at[d] = -1; g_rebusy[d] = 1'b0;
    end
    t0 = cyc;
    start = 1'b1;
  endtask

  // mode 0: single pulse; 1: extra pulse at cycle 50; 2: start held through DONE
  task automatic sweep(input string nm, input int mode);
    int rel;
    arm();
    for (int i = 0; i < 320; i++) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      case (mode)
        0: start = 1'b0;
        1: start = (rel == 50);
        default: start = 1'b1;
      endcase
      if (done_at[0] >= 0 && done_at[1] >= 0 && rel > done_at[1] + 2) break;
    end
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      string p;
      p = {nm, (d == 0) ? "_rl1" : "_rl3"};
      check({p, "_done_cyc"}, 64'(done_at[d]), 64'(259 + 2 * d));
      check({p, "_nwrites"}, 64'(g_wr[d]), 64'(NB));
      check({p, "_bad_writes"}, 64'(g_wbad[d]), 64'd0);
      check({p, "_total"}, 64'(g_total[d]), 64'(exp_total));
      check({p, "_cdf_min"}, 64'(g_min[d]), 64'(exp_min));
      check({p, "_peak_bin"}, 64'(g_pb[d]), 64'(exp_pb));
      check({p, "_peak_count"}, 64'(g_pc[d]), 64'(exp_pc));
      check({p, "_overflow"}, 64'(g_ovf[d]), 64'(exp_ovf));
      check({p, "_busy_at_done"}, 64'(g_busy[d]), 64'd0);
      check({p, "_raddr_at_done"}, 64'(g_ra[d]), 64'd0);
      if (mode == 2) check({p, "_restart_busy"}, 64'(g_rebusy[d]), 64'd1);
    end
  endtask

  task automatic check_quiet(input string nm);
    check({nm, "_wen"}, 64'({we_a, we_b}), 64'd0);
    check({nm, "_busy"}, 64'({busy_a, busy_b}), 64'd0);
    check({nm, "_done"}, 64'({done_a, done_b}), 64'd0);
    check({nm, "_total"}, 64'({tot_a, tot_b}), 64'd0);
    check({nm, "_ovf"}, 64'({ovf_a, ovf_b}), 64'd0);
    check({nm, "_stats"}, 64'({min_a, pc_a, pb_a}) | 64'({min_b, pc_b, pb_b}), 64'd0);
    check({nm, "_raddr"}, 64'({ra_a, ra_b, wa_a, wa_b}), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic fill_ovf();
    foreach (hist[k]) hist[k] = 32'd0;
    hist[0] = 32'hFFFF_FFF0;
    hist[1] = 32'h20;
  endtask

  initial begin
    foreach (hist[k]) hist[k] = 32'd0;
    repeat (3) @(posedge clk);
    #1 check_quiet("in_reset");
    rst = 1'b0;
    @(posedge clk); #1 check_quiet("idle");

    hist[7] = 32'd4096;
    sweep("single_bin", 0);

    foreach (hist[k]) hist[k] = 32'd16;
    sweep("flat16_repulse", 1);

    foreach (hist[k]) hist[k] = 32'd0;
    sweep("all_zero", 0);

    fill_ovf();
    sweep("saturate", 0);

    for (int r = 0; r < 4; r++) begin
      foreach (hist[k]) begin
        case (r)
          0: hist[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1000) : 32'd0;
          1: hist[k] = $urandom_range(0, 1 << 20);
          2: hist[k] = $urandom_range(0, 7);
          default: hist[k] = $urandom & 32'h03FF_FFFF;
        endcase
      end
      if (r == 2) hist[200] = 32'd50;
      sweep($sformatf("random%0d", r), 0);
    end

    fill_ovf();
    arm();
    for (int i = 0; i < 200 && cyc - t0 < 100; i++) begin
      @(posedge clk); #1 start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1 check_quiet("mid_reset");
    rst = 1'b0;

    foreach (hist[k]) hist[k] = $urandom_range(0, 5000);
    sweep("after_reset", 0);

    foreach (hist[k]) hist[k] = 32'd16;
    sweep("held_start", 2);
    do_reset();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/histogram_cdf.md
Name: histogram_cdf

Overview:
Downstream consumer of the histogram kernel. After the histogram RAM (256 bins x 32-bit) is complete, this block sweeps it once and writes the cumulative distribution to a CDF RAM of the same shape. During the sweep it also produces summary statistics for the equalisation stage: total count, first non-zero CDF value, and peak bin. Its start input is driven by the histogram kernel's valid. It reads the histogram RAM through that RAM's spare read port.

Parameters:
NUM_BINS, 256, number of bins swept (indices 0..NUM_BINS-1)
ADDR_WIDTH, 8, bin address width; must satisfy 2^ADDR_WIDTH >= NUM_BINS
DATA_WIDTH, 32, bin count / CDF width
READ_LATENCY, 1, cycles from hist_raddr to hist_rdata valid (synchronous RAM); legal values 1..4

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin sweep; level or pulse; sampled only in IDLE or DONE
hist_raddr  out  ADDR_WIDTH  histogram read address
hist_rdata  in  DATA_WIDTH  histogram read data, READ_LATENCY cycles after address
cdf_waddr  out  ADDR_WIDTH  CDF RAM write address
cdf_wdata  out  DATA_WIDTH  CDF value
cdf_wen  out  1  CDF write strobe
busy  out  1  sweep in progress
done  out  1  sweep complete; held until next accepted start
total  out  DATA_WIDTH  final CDF value (sum of all bins, saturated)
cdf_min  out  DATA_WIDTH  first non-zero CDF value; 0 if all bins are zero
peak_bin  out  ADDR_WIDTH  index of the largest bin; lowest index wins ties
peak_count  out  DATA_WIDTH  count in peak_bin
overflow  out  1  sticky: the running sum saturated during this sweep

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock.
- On reset, every output is 0, the FSM goes to IDLE and any sweep in progress is abandoned. cdf_wen is 0 in the cycle after rst is sampled.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE / DONE: if start is sampled high (cycle 0):
  - clear the accumulator, cdf_min, peak_bin, peak_count and overflow;
  - clear done, set busy;
  - go to ISSUE.
- ISSUE: hist_raddr = k in cycle k+1, for k = 0..NUM_BINS-1, one read per cycle, no bubbles. After the last address, go to DRAIN.
- DRAIN: wait until all reads in flight have returned, then go to DONE.
- Data path:
  - Data for address k arrives in cycle k+1+READ_LATENCY.
  - It is added to the accumulator in that cycle.
  - The CDF write is registered: cdf_wen=1, cdf_waddr=k, cdf_wdata=cdf[k] in cycle k+2+READ_LATENCY.
  - Track the in-flight index with a READ_LATENCY-deep valid/address shift register.
- Timing: the last write is in cycle NUM_BINS+1+READ_LATENCY. done=1 and busy=0 from cycle NUM_BINS+2+READ_LATENCY (259 for the defaults).
- Accumulation: cdf[k] = min(cdf[k-1] + hist[k], 2^DATA_WIDTH-1), with cdf[-1] = 0. Compute with a DATA_WIDTH+1-bit sum. On carry-out, saturate and set overflow.
- cdf_min: latched from the first bin k where cdf[k] != 0; not updated afterwards.
- Peak: update only when hist[k] > peak_count (strict), so ties keep the lower index.
- total, cdf_min, peak_bin, peak_count and overflow:
  - valid when done=1;
  - held stable until the next accepted start;
  - in-progress values are visible while busy and are don't-care.
- start while busy: ignored; the sweep is not restarted.
- start held high in DONE: starts a new sweep in the next cycle.
- hist_raddr holds 0 when not in ISSUE.
- cdf_wen is 0 except for exactly NUM_BINS cycles per sweep.
- cdf_waddr and cdf_wdata are don't-care when cdf_wen=0.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, ISSUE, DRAIN, DONE);
  - default NUM_BINS / ADDR_WIDTH / DATA_WIDTH constants, shared with the histogram kernel so the RAM shapes agree;
  - SAT_MAX constant.
- One natural sub-module: cdf_sat_accum. It holds the saturating accumulator plus the overflow flag, with inputs clear, en and din, and outputs sum and carry-out-sticky. Peak and cdf_min tracking stay inline.

Test Plan:
- hist[7]=4096, all other bins 0; start pulse -> cdf[0..6]=0, cdf[7..255]=4096; total=4096, cdf_min=4096, peak_bin=7, peak_count=4096, overflow=0; done first high at cycle 259.
- All bins = 16 -> cdf[k]=16*(k+1); total=4096, cdf_min=16, peak_bin=0 (tie rule), peak_count=16; exactly 256 cdf_wen cycles.
- All bins 0 -> all cdf writes 0; total=0, cdf_min=0, peak_bin=0, peak_count=0.
- hist[0]=0xFFFFFFF0, hist[1]=0x20, others 0 -> cdf[0]=0xFFFFFFF0; cdf[1..255]=0xFFFFFFFF; overflow=1; total=0xFFFFFFFF; peak_bin=0.
- Assert rst at cycle 100 of a sweep -> cdf_wen=0, busy=0, done=0 next cycle. A fresh start then completes a correct sweep with overflow cleared.
- start re-pulsed at cycle 50 -> ignored, done still at cycle 259. start held high through DONE -> second sweep begins at cycle 260; repeat with READ_LATENCY=3 -> done at cycle 261.
